fetch_unit: RTL

- Instruction fetch stage plus IF/ID pipeline latch of the five-stage MIPS pipeline.
- Owns the PC and issues word reads to the icache through the iREN/ihit handshake.
- Registers each fetched instruction with its PC+4 for the decode-stage control unit and register file.
- Honours stall from the hazard unit and PC redirect (taken branch, J/JAL, JR) from the later stages.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline latch for the five-stage MIPS pipeline.
// Defining FETCH_HALT_EN makes an all-ones instruction word halt fetching until a redirect.
module fetch_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q,   npc_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q,   cnt_d;
    logic        halted;
    logic        accept;

    // An icache word is only taken when nothing of higher priority claims the cycle.
    assign accept = ihit && !redirect && !stall && !halted;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = RUN;
        end else if (accept && (imemload == HALT_WORD)) begin
            state_d = HALTED;
        end
    end

    assign halted = (state_q == HALTED);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            npc_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (accept) begin
            instr_d = imemload;
            npc_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            cnt_d   = cnt_q + 32'd1;
        end else begin
            // Miss, or halted with decode free: present a bubble, keep npc for debug.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q    <= PC_INIT;
            instr_q <= NOP_INSTR;
            npc_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
            cnt_q   <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign iREN      = nRST && !halted;
    assign imemaddr  = pc_q;
    assign instr_out = instr_q;
    assign npc_out   = npc_q;
    assign valid_out = valid_q;
    assign fetch_cnt = cnt_q;

endmodule
